// File: rtl/btm_pkg.sv
// btm_pkg: shared definitions for the btm_pipe rounding multiplier.
//   - default configuration localparams (DA, DB, DAC_MAX, DW, CW, PW, OW)
//   - clamp_dac : limits the requested dac to the largest honoured value
//   - rnd_hu    : round-half-up right shift, (x + half) >> d
// Both helpers work on 32-bit unsigned values so they serve any operand width
// up to 31 bits; callers slice the result back to their own width.
package btm_pkg;

  localparam int DA      = 10;
  localparam int DB      = 10;
  localparam int DAC_MAX = 4;
  localparam int DW      = 3;
  localparam int CW      = 16;
  localparam int PW      = DA + DB + 2;  // product of two (width+1)-bit operands
  localparam int OW      = DA + DB;      // result width

  function automatic int unsigned clamp_dac(input int unsigned d,
                                            input int unsigned dmax);
    return (d > dmax) ? dmax : d;
  endfunction

  // The caller's operand is zero-extended into 32 bits, so the rounding carry
  // is kept (the result may equal 2**(width-d)).
  function automatic logic [31:0] rnd_hu(input logic [31:0] x,
                                         input int unsigned d);
    logic [31:0] half;
    half = (d == 0) ? 32'd0 : (32'd1 << (d - 1));
    return (x + half) >> d;
  endfunction

endpackage

// File: rtl/btm_pipe_stage.sv
// btm_pipe_stage: one valid/ready register slice of width W.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_valid, o_ready  upstream side of the handshake
//   i_data            payload from upstream
//   o_valid, i_ready  downstream side of the handshake
//   o_data            registered payload
// Handshake: a beat transfers on a rising clock edge when valid and ready are
// both high on that interface; valid never depends on ready, and the payload
// stays stable while valid is high and ready is low.
// The slice loads when it is empty or when its current beat leaves on the
// same edge, so o_ready is combinational from i_ready.
module btm_pipe_stage #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  assign o_ready = !o_valid || i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (o_ready) begin
      o_valid <= i_valid;
      if (i_valid) o_data <= i_data;
    end
  end

endmodule

// File: rtl/btm_pipe.sv
// btm_pipe: pipelined, runtime-configurable rounding multiplier.
// Each operand drops dac LSBs with round-half-up, the reduced operands are
// multiplied, and the product is shifted back left by 2*dac.
// Pipeline: S1 round+clamp | S2 multiply | S3 shift+saturate, each stage a
// btm_pipe_stage slice. Latency 3, throughput 1 beat/cycle, 3 beats of
// buffering under backpressure.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_valid, o_ready   input beat handshake (o_ready combinational from i_ready)
//   i_a, i_b, i_dac    operands and requested LSB drop (clamped to DAC_MAX)
//   o_valid, i_ready   result handshake
//   o_c, o_sat, o_dac  approximate product, saturation flag, dac used
//   o_busy             any stage holds a beat
//   o_ops              wrapping count of result handshakes
// Build option: define BTM_SIGNED_EN for two's complement operands/result
// (magnitudes rounded, sign applied after the shift, no saturation).
module btm_pipe
  import btm_pkg::*;
#(
  parameter int DA      = btm_pkg::DA,
  parameter int DB      = btm_pkg::DB,
  parameter int DAC_MAX = btm_pkg::DAC_MAX,
  parameter int DW      = btm_pkg::DW,
  parameter int CW      = btm_pkg::CW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DA-1:0]    i_a,
  input  logic [DB-1:0]    i_b,
  input  logic [DW-1:0]    i_dac,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DA+DB-1:0] o_c,
  output logic             o_sat,
  output logic [DW-1:0]    o_dac,
  output logic             o_busy,
  output logic [CW-1:0]    o_ops
);

  localparam int LPW = DA + DB + 2;
  localparam int LOW = DA + DB;
  localparam int CFW = LPW + 2 * DAC_MAX;  // product after the widest shift
  localparam int S1W = 1 + DW + (DA + 1) + (DB + 1);
  localparam int S2W = 1 + DW + LPW;
  localparam int S3W = 1 + DW + LOW;

  // ---------------- S1: clamp dac, take magnitudes, round ----------------
  logic [DW-1:0]  d_in;
  logic [DA-1:0]  mag_a;
  logic [DB-1:0]  mag_b;
  logic           neg_in;
  logic [31:0]    ra_w, rb_w;
  logic [S1W-1:0] s1_din, s1_dout;
  logic           v1, rdy1, rdy2, rdy3;

  always_comb begin
    d_in = DW'(clamp_dac(32'(i_dac), DAC_MAX));
`ifdef BTM_SIGNED_EN
    mag_a  = i_a[DA-1] ? (~i_a + 1'b1) : i_a;
    mag_b  = i_b[DB-1] ? (~i_b + 1'b1) : i_b;
    neg_in = i_a[DA-1] ^ i_b[DB-1];
`else
    mag_a  = i_a;
    mag_b  = i_b;
    neg_in = 1'b0;
`endif
    ra_w   = rnd_hu(32'(mag_a), 32'(d_in));
    rb_w   = rnd_hu(32'(mag_b), 32'(d_in));
    s1_din = {neg_in, d_in, ra_w[DA:0], rb_w[DB:0]};
  end

  btm_pipe_stage #(.W(S1W)) u_s1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(rdy1),
    .i_data (s1_din),
    .o_valid(v1),
    .i_ready(rdy2),
    .o_data (s1_dout)
  );

  // ---------------- S2: multiply ----------------
  logic           neg1;
  logic [DW-1:0]  d1;
  logic [DA:0]    ra1;
  logic [DB:0]    rb1;
  logic [LPW-1:0] p_in;
  logic [S2W-1:0] s2_dout;
  logic           v2;

  assign {neg1, d1, ra1, rb1} = s1_dout;
  assign p_in = {{(DB + 1){1'b0}}, ra1} * {{(DA + 1){1'b0}}, rb1};

  btm_pipe_stage #(.W(S2W)) u_s2 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(v1),
    .o_ready(rdy2),
    .i_data ({neg1, d1, p_in}),
    .o_valid(v2),
    .i_ready(rdy3),
    .o_data (s2_dout)
  );

  // ---------------- S3: shift back, saturate / apply sign ----------------
  logic           neg2;
  logic [DW-1:0]  d2;
  logic [LPW-1:0] p2;
  logic [CFW-1:0] c_full;
  logic           sat_raw;
  logic [LOW-1:0] c_in;
  logic           sat_in;
  logic [S3W-1:0] s3_dout;
  logic           v3;

  assign {neg2, d2, p2} = s2_dout;

  always_comb begin
    // d2 <= DAC_MAX, so the shift never exceeds the 2*DAC_MAX headroom.
    c_full  = {{(2 * DAC_MAX){1'b0}}, p2} << {d2, 1'b0};
    sat_raw = |c_full[CFW-1:LOW];
`ifdef BTM_SIGNED_EN
    // Magnitudes are bounded by 2**(width-1), so the shifted magnitude always
    // fits; negating a zero magnitude yields +0.
    c_in   = neg2 ? (~c_full[LOW-1:0] + 1'b1) : c_full[LOW-1:0];
    sat_in = 1'b0;
`else
    c_in   = sat_raw ? {LOW{1'b1}} : c_full[LOW-1:0];
    sat_in = sat_raw;
`endif
  end

  btm_pipe_stage #(.W(S3W)) u_s3 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(v2),
    .o_ready(rdy3),
    .i_data ({sat_in, d2, c_in}),
    .o_valid(v3),
    .i_ready(i_ready),
    .o_data (s3_dout)
  );

  // Upper bits of the 32-bit rounding helper are always zero; neg2/sat_raw are
  // only consumed in one of the two build variants.
  logic unused_bits;
  assign unused_bits = ^{ra_w[31:DA+1], rb_w[31:DB+1], neg2, sat_raw};

  // ---------------- outputs ----------------
  assign o_ready              = rdy1;
  assign o_valid              = v3;
  assign {o_sat, o_dac, o_c}  = s3_dout;
  assign o_busy               = v1 | v2 | v3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ops <= '0;
    end else if (v3 && i_ready) begin
      o_ops <= o_ops + 1'b1;
    end
  end

endmodule
